mc_ctrl: RTL and testbench

MC_CTRL -- requirements
Module: mc_ctrl

---
 rtl/mc_ctrl.sv | 220 ++++++++++++++++++++++
 tb/tb_mc_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset control FSM: FETCH/DECODE/EXEC/MEM/WB sequencing plus retired-instruction counter.
// Optional jal support is enabled by defining MC_CTRL_JAL_EN.
module mc_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  op,
    input  logic [5:0]  funct,
    input  logic        zero,
    output logic        pc_we,
    output logic        ir_we,
    output logic        reg_we,
    output logic        mem_we,
    output logic [1:0]  pc_src,
    output logic [1:0]  reg_dst,
    output logic [1:0]  wd_src,
    output logic        alu_src,
    output logic [1:0]  alu_op,
    output logic [1:0]  EOp,
    output logic [2:0]  state,
    output logic [31:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUBU  = 6'h23;

    localparam logic [1:0] PC_SEQ   = 2'd0;
    localparam logic [1:0] PC_BR    = 2'd1;
    localparam logic [1:0] PC_JMP   = 2'd2;
    localparam logic [1:0] ALU_ADD  = 2'd0;
    localparam logic [1:0] ALU_SUB  = 2'd1;
    localparam logic [1:0] ALU_OR   = 2'd2;
    localparam logic [1:0] EXT_SIGN = 2'd0;
    localparam logic [1:0] EXT_ZERO = 2'd1;
    localparam logic [1:0] EXT_LUI  = 2'd2;
    localparam logic [1:0] EXT_BR   = 2'd3;

`ifdef MC_CTRL_JAL_EN
    localparam logic JAL_EN = 1'b1;
`else
    localparam logic JAL_EN = 1'b0;
`endif

    logic [2:0]  state_r;
    logic [2:0]  next_state_s;
    logic [31:0] retired_r;
    logic        retire_s;
    logic        is_addu_s, is_subu_s, is_ori_s, is_lui_s;
    logic        is_lw_s, is_sw_s, is_beq_s, is_j_s, is_jal_s;
    logic        supported_s;
    logic [1:0]  eop_s;

    // Instruction classification and immediate-extender mode from the IR fields.
    always_comb begin
        is_addu_s   = (op == OP_RTYPE) && (funct == FN_ADDU);
        is_subu_s   = (op == OP_RTYPE) && (funct == FN_SUBU);
        is_ori_s    = (op == OP_ORI);
        is_lui_s    = (op == OP_LUI);
        is_lw_s     = (op == OP_LW);
        is_sw_s     = (op == OP_SW);
        is_beq_s    = (op == OP_BEQ);
        is_j_s      = (op == OP_J);
        is_jal_s    = JAL_EN && (op == OP_JAL);
        supported_s = is_addu_s | is_subu_s | is_ori_s | is_lui_s | is_lw_s
                    | is_sw_s | is_beq_s | is_j_s | is_jal_s;
        if (is_ori_s) begin
            eop_s = EXT_ZERO;
        end else if (is_lui_s) begin
            eop_s = EXT_LUI;
        end else if (is_beq_s) begin
            eop_s = EXT_BR;
        end else begin
            eop_s = EXT_SIGN;
        end
    end

    // Control outputs and next state; everything is held at 0 while reset is asserted.
    always_comb begin
        pc_we        = 1'b0;
        ir_we        = 1'b0;
        reg_we       = 1'b0;
        mem_we       = 1'b0;
        pc_src       = PC_SEQ;
        reg_dst      = 2'd0;
        wd_src       = 2'd0;
        alu_src      = 1'b0;
        alu_op       = ALU_ADD;
        EOp          = EXT_SIGN;
        next_state_s = S_FETCH;
        if (reset) begin
            next_state_s = S_FETCH;
        end else begin
            case (state_r)
                S_FETCH: begin
                    ir_we        = 1'b1;
                    pc_we        = 1'b1;
                    pc_src       = PC_SEQ;
                    next_state_s = S_DECODE;
                end
                S_DECODE: begin
                    EOp = eop_s;
                    if (is_j_s) begin
                        pc_we        = 1'b1;
                        pc_src       = PC_JMP;
                        next_state_s = S_FETCH;
                    end else if (is_jal_s) begin
                        pc_we        = 1'b1;
                        pc_src       = PC_JMP;
                        reg_we       = 1'b1;
                        reg_dst      = 2'd2;
                        wd_src       = 2'd2;
                        next_state_s = S_FETCH;
                    end else if (supported_s) begin
                        next_state_s = S_EXEC;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
                S_EXEC: begin
                    EOp = eop_s;
                    if (is_addu_s || is_subu_s) begin
                        alu_op       = is_subu_s ? ALU_SUB : ALU_ADD;
                        next_state_s = S_WB;
                    end else if (is_ori_s || is_lui_s) begin
                        alu_src      = 1'b1;
                        alu_op       = ALU_OR;
                        next_state_s = S_WB;
                    end else if (is_lw_s || is_sw_s) begin
                        alu_src      = 1'b1;
                        alu_op       = ALU_ADD;
                        next_state_s = S_MEM;
                    end else if (is_beq_s) begin
                        alu_op       = ALU_SUB;
                        pc_we        = zero;
                        pc_src       = PC_BR;
                        next_state_s = S_FETCH;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
                S_MEM: begin
                    EOp = eop_s;
                    if (is_sw_s) begin
                        mem_we       = 1'b1;
                        next_state_s = S_FETCH;
                    end else if (is_lw_s) begin
                        next_state_s = S_WB;
                    end else begin
                        next_state_s = S_FETCH;
                    end
                end
                S_WB: begin
                    EOp          = eop_s;
                    next_state_s = S_FETCH;
                    if (is_addu_s || is_subu_s) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'd1;
                        wd_src  = 2'd0;
                    end else if (is_ori_s || is_lui_s) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'd0;
                        wd_src  = 2'd0;
                    end else if (is_lw_s) begin
                        reg_we  = 1'b1;
                        reg_dst = 2'd0;
                        wd_src  = 2'd1;
                    end else begin
                        reg_we  = 1'b0;
                    end
                end
                default: begin
                    next_state_s = S_FETCH;
                end
            endcase
        end
    end

    // An instruction retires when a supported one hands control back to FETCH.
    always_comb begin
        retire_s = (state_r >= S_DECODE) && (state_r <= S_WB)
                && (next_state_s == S_FETCH) && supported_s && !reset;
    end

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= S_FETCH;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Retired-instruction counter, wraps silently.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_r <= 32'd0;
        end else if (retire_s) begin
            retired_r <= retired_r + 32'd1;
        end else begin
            retired_r <= retired_r;
        end
    end

    assign state   = state_r;
    assign retired = retired_r;

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: directed scenarios plus random instruction stream against
// a per-instruction path model. Define MC_CTRL_JAL_EN for both bench and RTL to test jal.
module tb_mc_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [5:0]  op, funct;
    logic        zero;
    logic        pc_we, ir_we, reg_we, mem_we, alu_src;
    logic [1:0]  pc_src, reg_dst, wd_src, alu_op, EOp;
    logic [2:0]  state;
    logic [31:0] retired;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt;

    typedef struct packed {
        logic [2:0] st;
        logic       pc_we, ir_we, reg_we, mem_we;
        logic [1:0] pc_src, reg_dst, wd_src;
        logic       alu_src;
        logic [1:0] alu_op, eop;
    } ctl_t;

    typedef enum int {K_ADDU, K_SUBU, K_ORI, K_LUI, K_LW, K_SW, K_BEQ, K_J, K_JAL, K_BAD} kind_t;

    always #5 clk = ~clk;

    mc_ctrl dut (
        .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
        .pc_we(pc_we), .ir_we(ir_we), .reg_we(reg_we), .mem_we(mem_we),
        .pc_src(pc_src), .reg_dst(reg_dst), .wd_src(wd_src), .alu_src(alu_src),
        .alu_op(alu_op), .EOp(EOp), .state(state), .retired(retired)
    );

    function automatic kind_t classify(input logic [5:0] o, input logic [5:0] f);
        kind_t k;
        case (o)
            6'h00: begin
                if (f == 6'h21) k = K_ADDU;
                else if (f == 6'h23) k = K_SUBU;
                else k = K_BAD;
            end
            6'h0D: k = K_ORI;
            6'h0F: k = K_LUI;
            6'h23: k = K_LW;
            6'h2B: k = K_SW;
            6'h04: k = K_BEQ;
            6'h02: k = K_J;
`ifdef MC_CTRL_JAL_EN
            6'h03: k = K_JAL;
`endif
            default: k = K_BAD;
        endcase
        return k;
    endfunction

    // Number of cycles the instruction spends before FETCH comes round again.
    function automatic int path_len(input kind_t k);
        if (k == K_J || k == K_JAL || k == K_BAD) return 2;
        if (k == K_BEQ) return 3;
        if (k == K_LW) return 5;
        return 4;
    endfunction

    // Expected controls at cycle i of an instruction, from the instruction's phase sequence.
    function automatic ctl_t expect_ctl(input kind_t k, input logic z, input int i);
        ctl_t e;
        logic [2:0] phases [5];
        phases[0] = 3'd0;
        phases[1] = 3'd1;
        phases[2] = 3'd2;
        phases[3] = (k == K_LW || k == K_SW) ? 3'd3 : 3'd4;
        phases[4] = 3'd4;
        e = '0;
        e.st = phases[i];
        if (i > 0) begin
            if (k == K_ORI) e.eop = 2'd1;
            else if (k == K_LUI) e.eop = 2'd2;
            else if (k == K_BEQ) e.eop = 2'd3;
            else e.eop = 2'd0;
        end
        case (e.st)
            3'd0: begin e.ir_we = 1'b1; e.pc_we = 1'b1; end
            3'd1: begin
                if (k == K_J || k == K_JAL) begin e.pc_we = 1'b1; e.pc_src = 2'd2; end
                if (k == K_JAL) begin e.reg_we = 1'b1; e.reg_dst = 2'd2; e.wd_src = 2'd2; end
            end
            3'd2: begin
                e.alu_src = (k == K_ORI || k == K_LUI || k == K_LW || k == K_SW);
                if (k == K_SUBU || k == K_BEQ) e.alu_op = 2'd1;
                else if (k == K_ORI || k == K_LUI) e.alu_op = 2'd2;
                else e.alu_op = 2'd0;
                if (k == K_BEQ) begin e.pc_we = z; e.pc_src = 2'd1; end
            end
            3'd3: e.mem_we = (k == K_SW);
            3'd4: begin
                e.reg_we  = 1'b1;
                e.reg_dst = (k == K_ADDU || k == K_SUBU) ? 2'd1 : 2'd0;
                e.wd_src  = (k == K_LW) ? 2'd1 : 2'd0;
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    function automatic ctl_t observe();
        ctl_t o;
        o.st = state; o.pc_we = pc_we; o.ir_we = ir_we; o.reg_we = reg_we; o.mem_we = mem_we;
        o.pc_src = pc_src; o.reg_dst = reg_dst; o.wd_src = wd_src; o.alu_src = alu_src;
        o.alu_op = alu_op; o.eop = EOp;
        return o;
    endfunction

    task automatic check_ctl(input string tag, input ctl_t obs, input ctl_t exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Runs one instruction from FETCH, checking every cycle; abort_step >= 0 stops after that step.
    task automatic run_instr(input string tag, input logic [5:0] o, input logic [5:0] f,
                             input logic z, input int abort_step);
        kind_t k;
        op = o; funct = f; zero = z;
        k = classify(o, f);
        #1;
        for (int i = 0; i < path_len(k); i++) begin
            check_ctl($sformatf("%s_step%0d", tag, i), observe(), expect_ctl(k, z, i));
            if (i == abort_step) return;
            @(negedge clk);
            #1;
        end
        if (k != K_BAD) model_cnt = model_cnt + 32'd1;
        check32({tag, "_retired"}, retired, model_cnt);
    endtask

    initial begin
        logic [5:0] ro, rf;
        int sel;
        reset = 1'b1; op = 6'h0D; funct = 6'h00; zero = 1'b0;
        model_cnt = 32'd0;
        @(negedge clk); @(negedge clk);
        check_ctl("reset_ctl", observe(), '0);
        check32("reset_retired", retired, 32'd0);
        reset = 1'b0;

        run_instr("ori", 6'h0D, 6'h15, 1'b0, -1);
        run_instr("beq_taken", 6'h04, 6'h00, 1'b1, -1);
        run_instr("beq_not", 6'h04, 6'h00, 1'b0, -1);
        run_instr("lw", 6'h23, 6'h00, 1'b0, -1);
        run_instr("sw", 6'h2B, 6'h00, 1'b0, -1);
        run_instr("addu", 6'h00, 6'h21, 1'b0, -1);
        run_instr("subu", 6'h00, 6'h23, 1'b1, -1);
        run_instr("lui", 6'h0F, 6'h00, 1'b0, -1);
        run_instr("j", 6'h02, 6'h00, 1'b0, -1);
        run_instr("op03", 6'h03, 6'h00, 1'b0, -1);
        run_instr("bad_funct", 6'h00, 6'h20, 1'b0, -1);
        run_instr("bad_op", 6'h3F, 6'h00, 1'b0, -1);

        // Abort a lw in WB with reset; nothing of it may retire.
        run_instr("lw_abort", 6'h23, 6'h00, 1'b0, 4);
        reset = 1'b1;
        #1;
        check_ctl("abort_ctl", observe(), '0);
        check32("abort_retired", retired, 32'd0);
        model_cnt = 32'd0;
        @(negedge clk);
        reset = 1'b0;
        run_instr("after_abort", 6'h0D, 6'h00, 1'b0, -1);

        // Counter wrap.
        force dut.retired_r = 32'hFFFF_FFFF;
        #1;
        release dut.retired_r;
        model_cnt = 32'hFFFF_FFFF;
        check32("preload", retired, 32'hFFFF_FFFF);
        run_instr("j_wrap", 6'h02, 6'h00, 1'b0, -1);
        check32("wrap_zero", retired, 32'd0);

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            rf  = 6'($urandom_range(0, 63));
            case (sel)
                0: begin ro = 6'h00; rf = 6'h21; end
                1: begin ro = 6'h00; rf = 6'h23; end
                2: ro = 6'h0D;
                3: ro = 6'h0F;
                4: ro = 6'h23;
                5: ro = 6'h2B;
                6: ro = 6'h04;
                7: ro = 6'h02;
                8: ro = 6'h03;
                default: ro = 6'($urandom_range(0, 63));
            endcase
            run_instr($sformatf("rnd%0d", n), ro, rf, 1'($urandom_range(0, 1)), -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
